// File: rtl/forward_hazard_unit_pkg.sv
// Shared encodings for the EX-stage forwarding/hazard unit: mux selects and
// stall FSM states.
package forward_hazard_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/forward_hazard_unit_fwd_select.sv
// Per-operand forwarding select: the newest producer (EX) wins over MEM,
// register $0 is never forwarded, and an unused operand always reads the RF.
module forward_hazard_unit_fwd_select
  import forward_hazard_unit_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              use_i,
  input  logic [REG_AW-1:0] src_i,
  input  logic [REG_AW-1:0] ex_dst_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] mem_dst_i,
  input  logic              mem_wr_i,
  output logic [1:0]        sel_o
);

  logic ex_hit_s;
  logic mem_hit_s;

  // A load in EX has no result yet, so it is excluded from the EX match
  always_comb begin
    ex_hit_s  = ex_regwrite_i && !ex_memread_i &&
                (ex_dst_i != {REG_AW{1'b0}}) && (ex_dst_i == src_i);
    mem_hit_s = mem_wr_i && (mem_dst_i != {REG_AW{1'b0}}) && (mem_dst_i == src_i);
  end

  // Priority select
  always_comb begin
    sel_o = FWD_RF;
    if (!use_i) begin
      sel_o = FWD_RF;
    end else if (ex_hit_s) begin
      sel_o = FWD_MEM;
    end else if (mem_hit_s) begin
      sel_o = FWD_WB;
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand-forwarding select and load-use stall control between ID and ID/EX,
// with a saturating stall-cycle counter.
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_count
);

  state_e            state_q, state_d;
  logic [REG_AW-1:0] mem_dst_q;
  logic              mem_wr_q;
  logic [1:0]        fwd_a_q, fwd_a_d;
  logic [1:0]        fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        sel_a_s;
  logic [1:0]        sel_b_s;
  logic              haz_s;
  logic              stall_s;

  forward_hazard_unit_fwd_select #(.REG_AW(REG_AW)) u_sel_a (
    .use_i         (id_use_rs),
    .src_i         (id_rs),
    .ex_dst_i      (ex_dst),
    .ex_regwrite_i (ex_regwrite),
    .ex_memread_i  (ex_memread),
    .mem_dst_i     (mem_dst_q),
    .mem_wr_i      (mem_wr_q),
    .sel_o         (sel_a_s)
  );

  forward_hazard_unit_fwd_select #(.REG_AW(REG_AW)) u_sel_b (
    .use_i         (id_use_rt),
    .src_i         (id_rt),
    .ex_dst_i      (ex_dst),
    .ex_regwrite_i (ex_regwrite),
    .ex_memread_i  (ex_memread),
    .mem_dst_i     (mem_dst_q),
    .mem_wr_i      (mem_wr_q),
    .sel_o         (sel_b_s)
  );

  // Load-use detection; gated by Rst_n so the pipeline stays enabled in reset
  always_comb begin
    haz_s = ex_memread && ex_regwrite && (ex_dst != {REG_AW{1'b0}}) &&
            ((id_use_rs && (ex_dst == id_rs)) || (id_use_rt && (ex_dst == id_rt))) &&
            !flush;
    stall_s = (state_q == RUN) && haz_s && Rst_n;
  end

  // Next-state, forward-select and counter logic
  always_comb begin
    state_d = state_q;
    fwd_a_d = sel_a_s;
    fwd_b_d = sel_b_s;
    cnt_d   = cnt_q;
    case (state_q)
      RUN:     state_d = stall_s ? STALL : RUN;
      STALL:   state_d = RUN;
      default: state_d = RUN;
    endcase
    if (flush || stall_s) begin
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
    end else begin
      fwd_a_d = sel_a_s;
      fwd_b_d = sel_b_s;
    end
    if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline state: FSM, MEM tracker, registered selects and stall counter
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= RUN;
      mem_dst_q <= {REG_AW{1'b0}};
      mem_wr_q  <= 1'b0;
      fwd_a_q   <= FWD_RF;
      fwd_b_q   <= FWD_RF;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      mem_dst_q <= ex_dst;
      mem_wr_q  <= ex_regwrite;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
      cnt_q     <= cnt_d;
    end
  end

  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;
  assign stall_count = cnt_q;
  assign pc_write    = !stall_s;
  assign ifid_write  = !stall_s;
  assign idex_bubble = stall_s;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit; counter width shrunk to 3 bits so
// saturation is reachable with a handful of stalls.
module tb_forward_hazard_unit;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 3;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic [REG_AW-1:0] id_rs, id_rt, ex_dst;
  logic              id_use_rs, id_use_rt, ex_regwrite, ex_memread, flush;
  logic [1:0]        fwd_a, fwd_b;
  logic              pc_write, ifid_write, idex_bubble;
  logic [CNT_W-1:0]  stall_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [CNT_W-1:0] exp_cnt;

  forward_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_dst(ex_dst),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .stall_count(stall_count)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt);
    id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
  endtask

  task automatic set_ex(input logic [4:0] dst, input logic rw, input logic mr, input logic fl);
    ex_dst = dst; ex_regwrite = rw; ex_memread = mr; flush = fl;
  endtask

  task automatic check_ctl(input string name, input logic exp_stall);
    #1;
    n_cmp++;
    if ({pc_write, ifid_write, idex_bubble} !== {!exp_stall, !exp_stall, exp_stall}) begin
      n_err++;
      $display("FAIL %s ctl: got pc=%b ifid=%b bub=%b want stall=%b", name, pc_write, ifid_write, idex_bubble, exp_stall);
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    set_id(5'd4, 1'b1, 5'd4, 1'b1);
    set_ex(5'd4, 1'b1, 1'b1, 1'b0);
    #2;
    check_ctl("reset", 1'b0);
    n_cmp++;
    if ({fwd_a, fwd_b, stall_count} !== {2'b00, 2'b00, 3'd0}) begin
      n_err++; $display("FAIL reset_regs: got %b %b %0d want 00 00 0", fwd_a, fwd_b, stall_count);
    end
    tick(); tick();
    set_id(5'd0, 1'b0, 5'd0, 1'b0);
    set_ex(5'd0, 1'b0, 1'b0, 1'b0);
    Rst_n = 1'b1;
    tick();
    exp_cnt = 3'd0;
  endtask

  task automatic test_ex_forward();
    set_id(5'd3, 1'b1, 5'd5, 1'b1);
    set_ex(5'd3, 1'b1, 1'b0, 1'b0);
    check_ctl("ex_fwd", 1'b0);
    tick();
    n_cmp++;
    if ({fwd_a, fwd_b} !== {2'b10, 2'b00}) begin
      n_err++; $display("FAIL ex_fwd: got a=%b b=%b want a=10 b=00", fwd_a, fwd_b);
    end
  endtask

  task automatic test_priority();
    set_id(5'd3, 1'b1, 5'd3, 1'b1);
    set_ex(5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if ({fwd_a, fwd_b} !== {2'b10, 2'b10}) begin
      n_err++; $display("FAIL prio_ex_wins: got a=%b b=%b want 10 10", fwd_a, fwd_b);
    end
    set_id(5'd3, 1'b1, 5'd7, 1'b1);
    set_ex(5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if ({fwd_a, fwd_b} !== {2'b01, 2'b10}) begin
      n_err++; $display("FAIL prio_mem_only: got a=%b b=%b want 01 10", fwd_a, fwd_b);
    end
    set_id(5'd7, 1'b1, 5'd7, 1'b0);
    set_ex(5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if ({fwd_a, fwd_b} !== {2'b01, 2'b00}) begin
      n_err++; $display("FAIL prio_unused: got a=%b b=%b want 01 00", fwd_a, fwd_b);
    end
  endtask

  task automatic test_load_use();
    set_id(5'd1, 1'b1, 5'd4, 1'b1);
    set_ex(5'd4, 1'b1, 1'b1, 1'b0);
    check_ctl("lu_stall", 1'b1);
    tick();
    exp_cnt = exp_cnt + 3'd1;
    n_cmp++;
    if ({fwd_a, fwd_b, stall_count} !== {2'b00, 2'b00, exp_cnt}) begin
      n_err++; $display("FAIL lu_bubble: got a=%b b=%b cnt=%0d want 00 00 %0d", fwd_a, fwd_b, stall_count, exp_cnt);
    end
    set_ex(5'd0, 1'b0, 1'b0, 1'b0);
    check_ctl("lu_release", 1'b0);
    tick();
    n_cmp++;
    if ({fwd_a, fwd_b, stall_count} !== {2'b00, 2'b01, exp_cnt}) begin
      n_err++; $display("FAIL lu_wb: got a=%b b=%b cnt=%0d want 00 01 %0d", fwd_a, fwd_b, stall_count, exp_cnt);
    end
  endtask

  task automatic test_flush();
    set_id(5'd3, 1'b1, 5'd4, 1'b1);
    set_ex(5'd4, 1'b1, 1'b1, 1'b1);
    check_ctl("flush_load", 1'b0);
    tick();
    n_cmp++;
    if ({fwd_a, fwd_b, stall_count} !== {2'b00, 2'b00, exp_cnt}) begin
      n_err++; $display("FAIL flush_load: got a=%b b=%b cnt=%0d want 00 00 %0d", fwd_a, fwd_b, stall_count, exp_cnt);
    end
    set_ex(5'd3, 1'b1, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if ({fwd_a, fwd_b} !== {2'b00, 2'b00}) begin
      n_err++; $display("FAIL flush_ex: got a=%b b=%b want 00 00", fwd_a, fwd_b);
    end
  endtask

  task automatic test_zero_reg();
    set_id(5'd0, 1'b1, 5'd0, 1'b1);
    set_ex(5'd0, 1'b1, 1'b1, 1'b0);
    check_ctl("zero_load", 1'b0);
    set_ex(5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if ({fwd_a, fwd_b} !== {2'b00, 2'b00}) begin
      n_err++; $display("FAIL zero_ex: got a=%b b=%b want 00 00", fwd_a, fwd_b);
    end
    set_ex(5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if ({fwd_a, fwd_b} !== {2'b00, 2'b00}) begin
      n_err++; $display("FAIL zero_mem: got a=%b b=%b want 00 00", fwd_a, fwd_b);
    end
  endtask

  task automatic test_back_to_back();
    set_id(5'd5, 1'b1, 5'd4, 1'b1);
    set_ex(5'd4, 1'b1, 1'b1, 1'b0);
    check_ctl("b2b_first", 1'b1);
    tick();
    exp_cnt = exp_cnt + 3'd1;
    set_ex(5'd5, 1'b1, 1'b1, 1'b0);
    check_ctl("b2b_in_stall", 1'b0);
    tick();
    n_cmp++;
    if (stall_count !== exp_cnt) begin
      n_err++; $display("FAIL b2b_cnt: got %0d want %0d", stall_count, exp_cnt);
    end
    check_ctl("b2b_again", 1'b1);
    tick();
    exp_cnt = exp_cnt + 3'd1;
    set_ex(5'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 6; i++) begin
      set_id(5'd6, 1'b1, 5'd0, 1'b0);
      set_ex(5'd6, 1'b1, 1'b1, 1'b0);
      check_ctl("sat_stall", 1'b1);
      tick();
      if (exp_cnt != 3'd7) exp_cnt = exp_cnt + 3'd1;
      set_ex(5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if (stall_count !== exp_cnt) begin
        n_err++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, stall_count, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    set_id(5'd2, 1'b1, 5'd0, 1'b0);
    set_ex(5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd8, 1'b1, 5'd8, 1'b1);
    set_ex(5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    set_ex(5'd8, 1'b1, 1'b1, 1'b0);
    Rst_n = 1'b0;
    check_ctl("rst_mid", 1'b0);
    n_cmp++;
    if ({fwd_a, fwd_b, stall_count} !== {2'b00, 2'b00, 3'd0}) begin
      n_err++; $display("FAIL rst_mid_regs: got %b %b %0d want 00 00 0", fwd_a, fwd_b, stall_count);
    end
    set_ex(5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    Rst_n = 1'b1;
    tick();
    set_ex(5'd8, 1'b1, 1'b1, 1'b0);
    check_ctl("rst_then_stall", 1'b1);
    tick();
    n_cmp++;
    if (stall_count !== 3'd1) begin
      n_err++; $display("FAIL rst_then_cnt: got %0d want 1", stall_count);
    end
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_priority();
    test_load_use();
    test_flush();
    test_zero_reg();
    test_back_to_back();
    test_saturation();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
